custom_axi_lite_regs: RTL
=========================

# custom_axi_lite_regs

AXI4-Lite slave register file sitting directly upstream of the custom IP core: it turns bus writes into the core's `ipreg_data`/`enable` inputs and exposes the core's result and state for reads. It holds the input operand, generates a one-cycle start pulse, and latches sticky completion and error flags. One outstanding read and one outstanding write at a time.

## Interface
- `ADDR_WIDTH`, 4, byte-address width; bits [3:2] select the register, bits [1:0] are ignored.
- `DATA_WIDTH`, 32, bus and operand width; only 32 is supported.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `s_axi_awaddr`/`awvalid`/`awready`  in/in/out  ADDR_WIDTH/1/1  write address channel.
- `s_axi_wdata`/`wstrb`/`wvalid`/`wready`  in/in/in/out  32/4/1/1  write data channel.
- `s_axi_bresp`/`bvalid`/`bready`  out/out/in  2/1/1  write response channel.
- `s_axi_araddr`/`arvalid`/`arready`  in/in/out  ADDR_WIDTH/1/1  read address channel.
- `s_axi_rdata`/`rresp`/`rvalid`/`rready`  out/out/out/in  32/2/1/1  read data channel.
- `ipreg_data_o`  out  32  operand to the core (the DATA_IN register).
- `enable_o`  out  1  one-cycle start pulse to the core.
- `ipreg_data_i`  in  32  result from the core.
- `status_i`  in  2  core state, `status_e` encoding: IDLE=0, BUSY=1, DONE=2, ERROR=3.

## Operation
- Register map:
  - 0x0 CTRL: bit0 START, write-1 only; reads as 0.
  - 0x4 DATA_IN: read/write, byte-strobed; drives `ipreg_data_o`.
  - 0x8 DATA_OUT: read-only; returns `ipreg_data_i` live.
  - 0xC STATUS: [1:0] live `status_i`; bit8 DONE_STICKY; bit9 ERR_STICKY. Both sticky bits are write-1-to-clear; all other bits read 0.
- START is honoured only if `wstrb[0]`=1, `wdata[0]`=1 and `status_i`==IDLE in the cycle the write executes. It then pulses `enable_o` for exactly one cycle.
- START while `status_i`≠IDLE: no pulse, BRESP=SLVERR (2'b10).
- Writes to DATA_OUT or to an unmapped offset: no effect, BRESP=SLVERR. All other writes return OKAY (2'b00), including a CTRL write with START=0.
- Reads of an unmapped offset: RDATA=0, RRESP=SLVERR. No unmapped offset exists with ADDR_WIDTH=4.
- DONE_STICKY is set on any cycle with `status_i`==DONE; ERR_STICKY is set on any cycle with `status_i`==ERROR.
- If a sticky bit is set and cleared in the same cycle, the set wins.
- WSTRB: byte n of DATA_IN updates only if `wstrb[n]`. A sticky-clear takes effect only if `wstrb[1]`=1.

## Timing
- Reset (synchronous, `rst_i` high at a rising edge) forces the following to 0: all ready and valid outputs, `bresp`, `rresp`, `rdata`, `ipreg_data_o`, `enable_o`, both sticky bits, and the AW/W buffers. Readies rise in the first cycle after reset is released.
- Reset mid-transaction discards the transaction; no B or R beat is ever issued for it.
- AW and W are accepted independently in any order or together:
  - `awready` is high while no address is buffered and `bvalid` is low.
  - `wready` is high while no data is buffered and `bvalid` is low.
- Write execution: once both AW and W are held (at the latest at the cycle-N handshake), the register update, `enable_o` pulse and `bvalid` are all visible in cycle N+1.
  - `bvalid` and `bresp` are held stable until `bready`.
  - The earliest next AW/W acceptance is the cycle after the B handshake.
- Read: `arready` = !`rvalid`. An AR handshake in cycle N gives `rvalid`, `rdata` and `rresp` in N+1, sampled from state at the end of cycle N. These are held stable until `rready`.
- Read and write channels are fully concurrent. A read of DATA_IN in the same cycle as a write executes returns the old value.
- `enable_o` is never high for two consecutive cycles, because the minimum spacing between writes is 2 cycles.

## Test plan
- Reset, then read all four registers → DATA_IN=0, STATUS=0x0 with `status_i`=0, CTRL=0, all RRESP=OKAY; `enable_o` stays 0.
- Write DATA_IN=0xDEADBEEF with `wstrb`=0xF, then write `wstrb`=0x2 with data 0x00001200 → `ipreg_data_o`=0xDEAD12EF; both BRESP=OKAY.
- W driven 3 cycles before AW, then CTRL=0x1 with `status_i`=IDLE → exactly one `enable_o` pulse, in the cycle `bvalid` rises; BRESP=OKAY; with `bready` held low for 4 cycles, `bvalid` stays high and `awready` stays low.
- CTRL=0x1 with `status_i`=BUSY → no pulse, BRESP=SLVERR.
- Drive `status_i` 1→2→0 with `ipreg_data_i`=0x5 → STATUS reads 0x100 and DATA_OUT reads 0x5; write STATUS=0x100 → reads 0x000.
- Write STATUS=0x100 while `status_i`==DONE → DONE_STICKY stays 1 (set wins). Assert `rst_i` with AR accepted and `rvalid` pending → `rvalid`=0 after reset and no R beat is issued.

Source files
------------

// File: rtl/custom_axi_lite_regs.sv
// AXI4-Lite slave register file in front of the custom IP core.
//
// Register map (byte offsets, address bits [3:2] select, [1:0] ignored):
//   0x0 CTRL     bit0 START (write-1, reads 0); pulses enable_o when the core is IDLE
//   0x4 DATA_IN  byte-strobed operand, drives ipreg_data_o
//   0x8 DATA_OUT read-only, live ipreg_data_i
//   0xC STATUS   [1:0] live status_i, bit8 DONE_STICKY, bit9 ERR_STICKY (W1C via wstrb[1])
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_axi_aw*/w*/b*         write address / data / response channels
//   s_axi_ar*/r*            read address / data channels
//   ipreg_data_o, enable_o  operand and one-cycle start pulse to the core
//   ipreg_data_i, status_i  result and state from the core
module custom_axi_lite_regs #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   ipreg_data_o,
    output logic                    enable_o,
    input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
    input  logic [1:0]              status_i
);

    typedef enum logic [1:0] {
        StatIdle  = 2'd0,
        StatBusy  = 2'd1,
        StatDone  = 2'd2,
        StatError = 2'd3
    } status_e;

    localparam logic [1:0] RegCtrl    = 2'd0;
    localparam logic [1:0] RegDataIn  = 2'd1;
    localparam logic [1:0] RegDataOut = 2'd2;
    localparam logic [1:0] RegStatus  = 2'd3;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    // Held low through reset so no handshake is possible until the cycle after release.
    logic                  ready_en_q, ready_en_d;
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NumBytes-1:0]   w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                  wr_exec;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NumBytes-1:0]   wr_strb;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  unused_addr_bits;

    assign s_axi_awready = ready_en_q & ~aw_full_q & ~bvalid_q;
    assign s_axi_wready  = ready_en_q & ~w_full_q & ~bvalid_q;
    assign s_axi_arready = ready_en_q & ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign ipreg_data_o  = data_in_q;
    assign enable_o      = enable_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign b_hs  = bvalid_q & s_axi_bready;
    assign r_hs  = rvalid_q & s_axi_rready;

    // A beat arriving this cycle is used directly so execution is not delayed by buffering.
    assign wr_addr = aw_full_q ? aw_addr_q : s_axi_awaddr;
    assign wr_data = w_full_q ? w_data_q : s_axi_wdata;
    assign wr_strb = w_full_q ? w_strb_q : s_axi_wstrb;
    assign wr_exec = (aw_full_q | aw_hs) & (w_full_q | w_hs);

    // Only bits [3:2] decode; the rest of each address is intentionally ignored.
    assign unused_addr_bits = ^{wr_addr, s_axi_araddr};

    // Read mux uses pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_value = '0;
        unique case (s_axi_araddr[3:2])
            RegCtrl:    rd_value = '0;
            RegDataIn:  rd_value = data_in_q;
            RegDataOut: rd_value = ipreg_data_i;
            RegStatus:  rd_value = {{(DATA_WIDTH-10){1'b0}}, err_q, done_q, 6'b0, status_i};
            default:    rd_value = '0;
        endcase
    end

    always_comb begin
        ready_en_d = 1'b1;
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        data_in_d  = data_in_q;
        enable_d   = 1'b0;
        done_d     = done_q;
        err_d      = err_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        // Readies are low while bvalid is high, so b_hs and wr_exec never coincide.
        if (b_hs) begin
            bvalid_d = 1'b0;
        end

        if (wr_exec) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RespOkay;
            unique case (wr_addr[3:2])
                RegCtrl: begin
                    if (wr_strb[0] && wr_data[0]) begin
                        if (status_i == StatIdle) begin
                            enable_d = 1'b1;
                        end else begin
                            bresp_d = RespSlvErr;
                        end
                    end
                end
                RegDataIn: begin
                    for (int b = 0; b < NumBytes; b++) begin
                        if (wr_strb[b]) begin
                            data_in_d[8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
                RegDataOut: bresp_d = RespSlvErr;
                RegStatus: begin
                    if (wr_strb[1]) begin
                        if (wr_data[8]) done_d = 1'b0;
                        if (wr_data[9]) err_d  = 1'b0;
                    end
                end
                default: bresp_d = RespSlvErr;
            endcase
        end

        // Setting after the clear makes a simultaneous set win.
        if (status_i == StatDone)  done_d = 1'b1;
        if (status_i == StatError) err_d  = 1'b1;

        if (r_hs) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_value;
            rresp_d  = RespOkay;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            data_in_q  <= '0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            data_in_q  <= data_in_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule
